// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle ARM-subset control path:
// FSM states, opcode/command fields, datapath mux selects and instruction classes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXECR  = 4'd2,
        EXECSH = 4'd3,
        ALUWB  = 4'd4,
        MEMADR = 4'd5,
        MEMRD  = 4'd6,
        MEMWR  = 4'd7,
        MEMWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_LSR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_LSL = 4'b0011;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic       SRCA_RD1   = 1'b0;
    localparam logic       SRCA_PC    = 1'b1;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;
    localparam logic       SH_LSL     = 1'b0;
    localparam logic       SH_LSR     = 1'b1;
    localparam logic [1:0] RES_RDATA  = 2'b00;
    localparam logic [1:0] RES_ALUOUT = 2'b01;
    localparam logic [1:0] RES_SHIFT  = 2'b10;
    localparam logic [1:0] RES_ALU    = 2'b11;

    // Bit positions in the one-hot instruction class vector.
    localparam int unsigned CLS_DP  = 0;
    localparam int unsigned CLS_CMP = 1;
    localparam int unsigned CLS_SH  = 2;
    localparam int unsigned CLS_MEM = 3;
    localparam int unsigned CLS_BR  = 4;
    localparam int unsigned CLS_N   = 5;

    function automatic logic is_dp_cmd(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// datapath enables and mux selects out.
interface multicycle_controller_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ex;
    logic       mem_ready;
    logic       ir_write;
    logic       pc_write;
    logic       adr_src;
    logic       mem_req;
    logic       mem_w;
    logic       reg_w;
    logic       flag_w;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic       sh_dir;
    logic [1:0] result_src;
    logic       illegal;
    logic       mem_timeout;

    modport master (
        input  op, funct, rd, cond_ex, mem_ready,
        output ir_write, pc_write, adr_src, mem_req, mem_w, reg_w, flag_w,
               alu_src_a, alu_src_b, alu_op, sh_dir, result_src, illegal, mem_timeout
    );

    modport slave (
        output op, funct, rd, cond_ex, mem_ready,
        input  ir_write, pc_write, adr_src, mem_req, mem_w, reg_w, flag_w,
               alu_src_a, alu_src_b, alu_op, sh_dir, result_src, illegal, mem_timeout
    );
endinterface

// File: rtl/multicycle_controller_instr_class_decode.sv
// Combinational classification of op/funct into a one-hot instruction class,
// flagging every encoding outside the supported subset as illegal.
module instr_class_decode
    import ctrl_pkg::*;
(
    input  logic [1:0]       op,
    input  logic             imm_sel,
    input  logic [3:0]       cmd,
    output logic [CLS_N-1:0] cls,
    output logic             illegal
);

    always_comb begin
        cls     = '0;
        illegal = 1'b0;
        unique case (op)
            OP_DP: begin
                // Only register-form ALU ops and register CMP; shift-select covers LSL/LSR alone.
                if (!imm_sel) begin
                    if (is_dp_cmd(cmd))        cls[CLS_DP]  = 1'b1;
                    else if (cmd == CMD_CMP)   cls[CLS_CMP] = 1'b1;
                    else                       illegal      = 1'b1;
                end else if ((cmd == CMD_LSL) || (cmd == CMD_LSR)) begin
                    cls[CLS_SH] = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_MEM: begin
                if (!imm_sel) cls[CLS_MEM] = 1'b1;
                else          illegal      = 1'b1;
            end
            OP_BR:   cls[CLS_BR] = 1'b1;
            default: illegal     = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback over one
// shared ALU and unified memory, with memory wait-state counting and conditional execution.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned STATE_W  = 4,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    logic [STATE_W-1:0] state_q;
    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               mem_timeout_q;
    logic [CLS_N-1:0]   cls;
    logic               cls_illegal;
    logic               rd_is_pc;
    logic               mem_wait;
    logic               stall;

    instr_class_decode u_decode (
        .op      (bus.op),
        .imm_sel (bus.funct[5]),
        .cmd     (bus.funct[4:1]),
        .cls     (cls),
        .illegal (cls_illegal)
    );

    assign state    = state_t'(state_q);
    assign rd_is_pc = (bus.rd == 4'd15);
    // A store that fails its condition never touches memory, so it cannot stall.
    assign mem_wait = (state == FETCH) || (state == MEMRD) ||
                      ((state == MEMWR) && bus.cond_ex);
    assign stall    = mem_wait && !bus.mem_ready;

    function automatic logic [STATE_W-1:0] enc(input state_t s);
        return STATE_W'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= enc(FETCH);
            wait_cnt      <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            // Saturating count of consecutive stalled cycles; pulse once on reaching WAIT_MAX.
            if (stall) begin
                if (wait_cnt != WAIT_W'(WAIT_MAX)) wait_cnt <= wait_cnt + WAIT_W'(1);
                mem_timeout_q <= (wait_cnt == WAIT_W'(WAIT_MAX - 1));
            end else begin
                wait_cnt      <= '0;
                mem_timeout_q <= 1'b0;
            end

            case (state)
                FETCH:  if (bus.mem_ready) state_q <= enc(DECODE);
                DECODE: begin
                    if (cls[CLS_DP] || cls[CLS_CMP]) state_q <= enc(EXECR);
                    else if (cls[CLS_SH])            state_q <= enc(EXECSH);
                    else if (cls[CLS_MEM])           state_q <= enc(MEMADR);
                    else if (cls[CLS_BR])            state_q <= enc(BRANCH);
                    else                             state_q <= enc(FETCH);
                end
                EXECR:  state_q <= cls[CLS_CMP] ? enc(FETCH) : enc(ALUWB);
                MEMADR: state_q <= bus.funct[0] ? enc(MEMRD) : enc(MEMWR);
                MEMRD:  if (bus.mem_ready) state_q <= enc(MEMWB);
                MEMWR:  if (!bus.cond_ex || bus.mem_ready) state_q <= enc(FETCH);
                EXECSH, ALUWB, MEMWB, BRANCH: state_q <= enc(FETCH);
                default: state_q <= enc(FETCH);
            endcase
        end
    end

    assign bus.mem_timeout = mem_timeout_q;

    always_comb begin
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.adr_src    = ADR_PC;
        bus.mem_req    = 1'b0;
        bus.mem_w      = 1'b0;
        bus.reg_w      = 1'b0;
        bus.flag_w     = 1'b0;
        bus.alu_src_a  = SRCA_RD1;
        bus.alu_src_b  = SRCB_RD2;
        bus.alu_op     = 1'b0;
        bus.sh_dir     = SH_LSL;
        bus.result_src = RES_RDATA;
        bus.illegal    = 1'b0;
        case (state)
            FETCH: begin
                bus.mem_req    = 1'b1;
                bus.adr_src    = ADR_PC;
                bus.alu_src_a  = SRCA_PC;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_a = SRCA_PC;
                bus.alu_src_b = SRCB_FOUR;
                bus.illegal   = cls_illegal;
            end
            EXECR: begin
                bus.alu_src_b = SRCB_RD2;
                bus.alu_op    = 1'b1;
                bus.flag_w    = bus.cond_ex && (cls[CLS_CMP] || bus.funct[0]);
            end
            EXECSH: begin
                bus.result_src = RES_SHIFT;
                bus.sh_dir     = (bus.funct[4:1] == CMD_LSR) ? SH_LSR : SH_LSL;
                bus.reg_w      = bus.cond_ex;
            end
            ALUWB: begin
                bus.result_src = RES_ALUOUT;
                bus.reg_w      = bus.cond_ex && !rd_is_pc;
                bus.pc_write   = bus.cond_ex && rd_is_pc;
            end
            MEMADR: begin
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = 1'b0;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = ADR_ALUOUT;
            end
            MEMWR: begin
                bus.adr_src = ADR_ALUOUT;
                bus.mem_req = bus.cond_ex;
                bus.mem_w   = bus.cond_ex;
            end
            MEMWB: begin
                bus.result_src = RES_RDATA;
                bus.reg_w      = bus.cond_ex && !rd_is_pc;
                bus.pc_write   = bus.cond_ex && rd_is_pc;
            end
            BRANCH: begin
                bus.alu_src_b  = SRCB_IMM;
                bus.result_src = RES_ALU;
                bus.pc_write   = bus.cond_ex;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its expected
// per-cycle control script, replayed against the DUT under random memory wait states.
module tb_multicycle_controller;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       adr_src;
        logic       mem_req;
        logic       mem_w;
        logic       reg_w;
        logic       flag_w;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic       sh_dir;
        logic [1:0] result_src;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t ready;
        ctl_t stall;
        bit   mem;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller #(.STATE_W(4), .WAIT_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    step_t steps[$];
    int    run_len;
    bit    exp_to;
    int    n_cyc, n_regw, n_memw, n_pcw, n_ill, n_to, n_flag, regw_cyc;
    logic  sh3;
    logic [1:0] res3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic ctl_t sample();
        ctl_t s;
        s.ir_write   = bus.ir_write;
        s.pc_write   = bus.pc_write;
        s.adr_src    = bus.adr_src;
        s.mem_req    = bus.mem_req;
        s.mem_w      = bus.mem_w;
        s.reg_w      = bus.reg_w;
        s.flag_w     = bus.flag_w;
        s.alu_src_a  = bus.alu_src_a;
        s.alu_src_b  = bus.alu_src_b;
        s.alu_op     = bus.alu_op;
        s.sh_dir     = bus.sh_dir;
        s.result_src = bus.result_src;
        s.illegal    = bus.illegal;
        return s;
    endfunction

    function automatic void push(input ctl_t c, input bit mem);
        step_t s;
        s.ready = c;
        s.stall = c;
        s.mem   = mem;
        steps.push_back(s);
    endfunction

    // Expands one instruction into its cycle script and replays it, comparing every cycle.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                             input logic c, input int fw, input int mw);
        ctl_t  t;
        step_t s;
        step_t cur;
        int    kind;
        int    wl;
        logic [3:0] cmd;
        logic  ready, stalled;
        ctl_t  act, expv;

        cmd = funct[4:1];
        // kinds: 0 illegal, 1 ALU op, 2 CMP, 3 shift, 4 LDR, 5 STR, 6 B
        if (op == 2'b10)      kind = 6;
        else if (op == 2'b01) kind = funct[5] ? 0 : (funct[0] ? 4 : 5);
        else if (op == 2'b00) begin
            if (!funct[5])
                kind = (cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd0 || cmd == 4'd12) ? 1 :
                       (cmd == 4'd10) ? 2 : 0;
            else
                kind = (cmd == 4'd3 || cmd == 4'd1) ? 3 : 0;
        end else kind = 0;

        steps.delete();
        t = '0; t.mem_req = 1; t.alu_src_a = 1; t.alu_src_b = 2'b10; t.result_src = 2'b11;
        s.stall = t; t.ir_write = 1; t.pc_write = 1; s.ready = t; s.mem = 1;
        steps.push_back(s);
        t = '0; t.alu_src_a = 1; t.alu_src_b = 2'b10; t.illegal = (kind == 0);
        push(t, 0);
        case (kind)
            1, 2: begin
                t = '0; t.alu_op = 1; t.flag_w = c & ((kind == 2) | funct[0]);
                push(t, 0);
                if (kind == 1) begin
                    t = '0; t.result_src = 2'b01;
                    t.reg_w = c & (rd != 4'd15); t.pc_write = c & (rd == 4'd15);
                    push(t, 0);
                end
            end
            3: begin
                t = '0; t.result_src = 2'b10; t.sh_dir = (cmd == 4'd1); t.reg_w = c;
                push(t, 0);
            end
            4, 5: begin
                t = '0; t.alu_src_b = 2'b01;
                push(t, 0);
                t = '0; t.adr_src = 1;
                if (kind == 4) begin
                    t.mem_req = 1; push(t, 1);
                    t = '0; t.result_src = 2'b00;
                    t.reg_w = c & (rd != 4'd15); t.pc_write = c & (rd == 4'd15);
                    push(t, 0);
                end else if (c) begin
                    t.mem_req = 1; t.mem_w = 1; push(t, 1);
                end else begin
                    push(t, 0);
                end
            end
            6: begin
                t = '0; t.alu_src_b = 2'b01; t.result_src = 2'b11; t.pc_write = c;
                push(t, 0);
            end
            default: ;
        endcase

        bus.op = op; bus.funct = funct; bus.rd = rd; bus.cond_ex = c;
        n_cyc = 0; n_regw = 0; n_memw = 0; n_pcw = 0; n_ill = 0; n_to = 0; n_flag = 0;
        regw_cyc = 0; sh3 = 1'bx; res3 = 2'bxx;
        wl = fw;
        while (steps.size() > 0) begin
            if (n_cyc > 200) begin
                check("cycle_budget", 32'(n_cyc), 32'd200);
                break;
            end
            cur = steps[0];
            ready = cur.mem ? (wl == 0) : 1'($urandom_range(0, 1));
            bus.mem_ready = ready;
            @(negedge clk);
            act  = sample();
            expv = (cur.mem && !ready) ? cur.stall : cur.ready;
            check("ctl", 32'(act), 32'(expv));
            check("mem_timeout", 32'(bus.mem_timeout), 32'(exp_to));
            n_cyc++;
            if (act.reg_w) begin n_regw++; regw_cyc = n_cyc; end
            n_memw += int'(act.mem_w);
            n_pcw  += int'(act.pc_write);
            n_ill  += int'(act.illegal);
            n_flag += int'(act.flag_w);
            n_to   += int'(bus.mem_timeout);
            if (n_cyc == 3) begin sh3 = act.sh_dir; res3 = act.result_src; end
            stalled = cur.mem && !ready;
            if (stalled) begin run_len++; wl--; end
            else run_len = 0;
            exp_to = stalled && (run_len == 15);
            if (!stalled) begin
                void'(steps.pop_front());
                wl = mw;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [1:0] op;
        logic [5:0] funct;
        reset = 1'b1;
        bus.op = '0; bus.funct = '0; bus.rd = '0; bus.cond_ex = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check("rst_mem_req",  32'(bus.mem_req),     32'd1);
        check("rst_adr_src",  32'(bus.adr_src),     32'd0);
        check("rst_ir_write", 32'(bus.ir_write),    32'd0);
        check("rst_pc_write", 32'(bus.pc_write),    32'd0);
        check("rst_mem_w",    32'(bus.mem_w),       32'd0);
        check("rst_reg_w",    32'(bus.reg_w),       32'd0);
        check("rst_timeout",  32'(bus.mem_timeout), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_len = 0; exp_to = 1'b0;

        run_instr(2'b00, 6'b001000, 4'd1, 1'b1, 0, 0);      // ADD r1
        check("add_cycles",  32'(n_cyc), 32'd4);
        check("add_regw",    32'(n_regw), 32'd1);
        check("add_regw_at", 32'(regw_cyc), 32'd4);

        run_instr(2'b01, 6'b011001, 4'd2, 1'b1, 0, 2);      // LDR, 2 waits
        check("ldr_cycles", 32'(n_cyc), 32'd7);
        check("ldr_regw",   32'(n_regw), 32'd1);

        run_instr(2'b01, 6'b011000, 4'd3, 1'b0, 0, 0);      // STR, condition false
        check("str_skip_cycles", 32'(n_cyc), 32'd4);
        check("str_skip_memw",   32'(n_memw), 32'd0);

        run_instr(2'b00, 6'b100011, 4'd4, 1'b1, 0, 0);      // LSR
        check("lsr_cycles", 32'(n_cyc), 32'd3);
        check("lsr_dir",    32'(sh3), 32'd1);
        check("lsr_res",    32'(res3), 32'd2);
        run_instr(2'b00, 6'b100111, 4'd4, 1'b1, 0, 0);      // LSL
        check("lsl_dir",    32'(sh3), 32'd0);

        run_instr(2'b11, 6'b001000, 4'd5, 1'b1, 0, 0);      // unsupported op
        check("ill_cycles", 32'(n_cyc), 32'd2);
        check("ill_pulse",  32'(n_ill), 32'd1);
        check("ill_regw",   32'(n_regw), 32'd0);
        check("ill_pcw",    32'(n_pcw), 32'd1);

        run_instr(2'b00, 6'b010101, 4'd0, 1'b1, 0, 0);      // CMP
        check("cmp_cycles", 32'(n_cyc), 32'd3);
        check("cmp_flagw",  32'(n_flag), 32'd1);
        run_instr(2'b10, 6'b000000, 4'd0, 1'b1, 0, 0);      // B
        check("b_cycles",   32'(n_cyc), 32'd3);
        run_instr(2'b01, 6'b011000, 4'd6, 1'b1, 0, 0);      // STR taken
        check("str_cycles", 32'(n_cyc), 32'd4);
        check("str_memw",   32'(n_memw), 32'd1);

        run_instr(2'b00, 6'b001000, 4'd1, 1'b1, 15, 0);     // 15 fetch waits
        check("to15_pulses", 32'(n_to), 32'd1);
        run_instr(2'b00, 6'b001000, 4'd1, 1'b1, 20, 0);     // saturation
        check("to20_pulses", 32'(n_to), 32'd1);
        check("to20_cycles", 32'(n_cyc), 32'd24);

        // Reset while a store is stalled in memory.
        bus.op = 2'b01; bus.funct = 6'b011000; bus.rd = 4'd0; bus.cond_ex = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("memwr_stall_w",   32'(bus.mem_w),   32'd1);
        check("memwr_stall_req", 32'(bus.mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_memwr_w",   32'(bus.mem_w),   32'd0);
        check("rst_memwr_adr", 32'(bus.adr_src), 32'd0);
        check("rst_memwr_req", 32'(bus.mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        run_len = 0; exp_to = 1'b0;

        for (int i = 0; i < 160; i++) begin
            int fw, mw;
            op    = 2'($urandom_range(0, 3));
            funct = 6'($urandom);
            if (op == 2'b00 && funct[5] && funct[4:1] == 4'b1010) funct[5] = 1'b0;
            fw = ($urandom_range(0, 11) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 11) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 2));
            run_instr(op, funct, ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                      1'($urandom_range(0, 1)), fw, mw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
